alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the combinational 8-bit ALU: buffers 16-bit instructions in a small FIFO, decodes operand fields, and reads a 4x8 register file.
- Drives the ALU's instruction/data0/data1 from registers, then captures the selected ALU output back into the register file one cycle later.
- Provides forwarding, a HALT/resume FSM, sticky flags and a retired-instruction counter.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries; power of 2, at least 2
CNT_W, 16, retired counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO can accept; equals !full
in_instr  in  16  instruction word
resume  in  1  one-cycle pulse; leaves HALTED
flush  in  1  synchronous; clears FIFO and the EXEC slot
alu_instruction  out  16  to ALU instruction
alu_data0  out  8  to ALU data0
alu_data1  out  8  to ALU data1
alu_out0..alu_out3  in  8 each  ALU result ports
alu_overflow  in  1  ALU overflow_flag
alu_zero  in  1  ALU zero_flag
wb_valid  out  1  register write this cycle
wb_addr  out  2  written register
wb_data  out  8  written value
flag_ovf  out  1  sticky overflow, cleared only by reset
flag_zero  out  1  zero flag of last written result
retired_count  out  CNT_W  instructions issued, wrapping
halted  out  1  FSM in HALTED
dbg_addr  in  2  debug read index
dbg_data  out  8  combinational read of reg[dbg_addr]

Behaviour:
- Instruction fields:
  - [15:14] dest register (same bits as ALU output select); [13:12] class; [11:10] op.
  - [9:8] rA; [7:6] rB; [5] imm_en; [4:0] imm.
- Operands: data0 = reg[rA]. data1 = imm_en ? {3'b0, imm} : reg[rB].
- Reset (async): FIFO empty; EXEC invalid; all regs 8'h00; all outputs 0; state IDLE. in_ready = 1 after reset.
- FIFO:
  - Push on in_valid && in_ready. Pop when state != HALTED and FIFO is not empty.
  - When full, in_ready = 0, with no same-cycle pass-through even if a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue edge: the popped instruction is latched into alu_instruction, alu_data0 and alu_data1, and EXEC becomes valid. One instruction issues per cycle, with no stalls.
- EXEC cycle (next cycle):
  - result = alu_out[dest], with dest = alu_instruction[15:14].
  - At the following edge: reg[dest] <= result, and wb_valid/addr/data are registered with it. flag_zero <= alu_zero; flag_ovf <= flag_ovf | alu_overflow.
  - Latency is 2 cycles from pop to register-file update.
- Forwarding: when EXEC is valid and writes back, and its dest equals the issuing rA or rB, the operand takes the EXEC result instead of reg[].
- Class 2'b10 is a control class: no writeback, and flags are unchanged.
  - op 2'b00 is NOP.
  - op 2'b11 is HALT.
  - ops 01 and 10 behave as NOP.
- FSM:
  - IDLE: FIFO empty. Goes to RUN when the FIFO is non-empty.
  - RUN: issues instructions. Goes to IDLE when the FIFO and EXEC are both empty.
  - HALTED: entered on the edge that issues a HALT. Issue stops, but FIFO pushes continue. Returns to RUN on resume; if the FIFO is empty it goes to IDLE instead.
  - resume outside HALTED is ignored.
- retired_count increments on every issue, including NOP and HALT.
- flush:
  - Empties the FIFO and invalidates EXEC, so the in-flight writeback is dropped.
  - State goes to IDLE; regs and flags are kept.
  - If flush coincides with a push, flush wins and the pushed word is dropped.
- Reset mid-operation aborts everything immediately; no partial writeback.

Decomposition:
- Package alu_issue_pkg holds:
  - field position localparams;
  - class enum: ARITH=00, LOGIC=01, CTRL=10, SPECIAL=11;
  - CTRL op constants: NOP, HALT;
  - state enum {IDLE, RUN, HALTED}.
- Sub-module alu_issue_fifo: synchronous FIFO (push, pop, flush, full, empty, dout), parameterised by depth and width.

Test Plan:
- Reset, push 16'h4825 (r1 = r0 + 5) -> wb_valid with wb_addr=1, wb_data=8'h05 two cycles after pop; flag_zero=0; retired_count=1.
- Push 16'h4825 then 16'h8923 (r2 = r1 + 3) back-to-back -> r2 = 8'h08 via forwarding; no bubble; writebacks on consecutive cycles.
- Push 16'hCC21 (r3 = r0 - 1) then 16'h0BC0 (r0 = r3 + r3) -> r3 = 8'hFF, r0 = 8'hFE, flag_ovf = 1 and still 1 after a later non-overflow add.
- Push 16'h2C00 (HALT) followed by 5 instructions -> halted=1, no issue; in_ready drops after the 4th buffered word; resume pulse -> 4 instructions issue in order.
- Push 16'h2000 (NOP) -> no wb_valid; flags unchanged; retired_count increments.
- Assert flush during EXEC of 16'h4825 -> no write to r1; FIFO empty; state IDLE. Assert rst mid-stream -> all regs 8'h00 and outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: instruction field layout, class/op codes and FSM states for the ALU issue stage
package alu_issue_pkg;
  localparam int DEST_LSB = 14;
  localparam int CLASS_LSB = 12;
  localparam int OP_LSB = 10;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 6;
  localparam int IMM_EN_BIT = 5;
  localparam int IMM_W = 5;
  typedef enum logic [1:0] {ARITH = 2'b00, LOGIC = 2'b01, CTRL = 2'b10, SPECIAL = 2'b11} class_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_HALT = 2'b11} ctrl_op_e;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
  function automatic logic [1:0] fld2(input logic [15:0] instr, input int lsb);
    return instr[lsb+:2];
  endfunction
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: synchronous FIFO with flush; pointers wrap naturally as DEPTH is a power of 2
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] dout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers instructions, reads/forwards operands into the ALU and writes the selected result back
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic             resume,
  input  logic             flush,
  output logic [15:0]      alu_instruction,
  output logic [7:0]       alu_data0,
  output logic [7:0]       alu_data1,
  input  logic [7:0]       alu_out0,
  input  logic [7:0]       alu_out1,
  input  logic [7:0]       alu_out2,
  input  logic [7:0]       alu_out3,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             wb_valid,
  output logic [1:0]       wb_addr,
  output logic [7:0]       wb_data,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  input  logic [1:0]       dbg_addr,
  output logic [7:0]       dbg_data
);
  logic [15:0] head, instr_q;
  logic [7:0] data0_q, data1_q, wb_data_q, result, op0, op1;
  logic [7:0] regs_q [4];
  logic full, empty, issue, exec_q, exec_wb, is_halt, wb_valid_q, flag_ovf_q, flag_zero_q;
  logic [1:0] ex_dest, ra, rb, wb_addr_q;
  logic [CNT_W-1:0] retired_q;
  state_e state_q, state_d;
  alu_issue_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk(clk), .rst(rst), .push_i(in_valid && in_ready), .pop_i(issue), .flush_i(flush),
    .din_i(in_instr), .full_o(full), .empty_o(empty), .dout_o(head)
  );
  assign in_ready = !full;
  assign ex_dest = fld2(instr_q, DEST_LSB);
  assign ra = fld2(head, RA_LSB);
  assign rb = fld2(head, RB_LSB);
  assign result = ex_dest[1] ? (ex_dest[0] ? alu_out3 : alu_out2) : (ex_dest[0] ? alu_out1 : alu_out0);
  assign exec_wb = exec_q && fld2(instr_q, CLASS_LSB) != CTRL;
  assign is_halt = fld2(head, CLASS_LSB) == CTRL && fld2(head, OP_LSB) == OP_HALT;
  assign issue = state_q != HALTED && !empty && !flush;
  // The EXEC result lands in regs_q on the same edge this instruction issues, so bypass it
  assign op0 = exec_wb && ex_dest == ra ? result : regs_q[ra];
  assign op1 = head[IMM_EN_BIT] ? 8'(head[IMM_W-1:0]) : exec_wb && ex_dest == rb ? result : regs_q[rb];
  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (issue && is_halt) state_d = HALTED;
    else if (state_q == HALTED) state_d = resume ? (empty ? IDLE : RUN) : HALTED;
    else if (state_q == IDLE) state_d = empty ? IDLE : RUN;
    else state_d = empty && !exec_q ? IDLE : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exec_q <= 1'b0;
      instr_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      retired_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_ovf_q <= 1'b0;
      flag_zero_q <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      exec_q <= issue;
      wb_valid_q <= exec_wb && !flush;
      if (issue) begin
        instr_q <= head;
        data0_q <= op0;
        data1_q <= op1;
        retired_q <= retired_q + 1'b1;
      end
      if (exec_wb && !flush) begin
        regs_q[ex_dest] <= result;
        wb_addr_q <= ex_dest;
        wb_data_q <= result;
        flag_zero_q <= alu_zero;
        flag_ovf_q <= flag_ovf_q | alu_overflow;
      end
    end
  end
  assign alu_instruction = instr_q;
  assign alu_data0 = data0_q;
  assign alu_data1 = data1_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign flag_ovf = flag_ovf_q;
  assign flag_zero = flag_zero_q;
  assign retired_count = retired_q;
  assign halted = state_q == HALTED;
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with an ALU stand-in and a writeback scoreboard fed from a sequential register model
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, resume, flush, alu_overflow, alu_zero, wb_valid, flag_ovf, flag_zero, halted;
  logic [15:0] in_instr, alu_instruction, retired_count;
  logic [7:0] alu_data0, alu_data1, alu_out0, alu_out1, alu_out2, alu_out3, wb_data, dbg_data;
  logic [1:0] wb_addr, dbg_addr;
  logic [8:0] alu_r;
  logic [7:0] m_regs [4] = '{default: 8'h00};
  logic [9:0] exp_q [$];
  logic [15:0] hv [5] = '{16'h8821, 16'hDC80, 16'h4E80, 16'h1940, 16'h4825};
  int compared = 0, mismatched = 0, cyc = 0, wb_cnt = 0, last_wb = 0, prev_wb = 0, push_edge = 0;
  int pe, rc, base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .resume(resume), .flush(flush), .alu_instruction(alu_instruction), .alu_data0(alu_data0),
    .alu_data1(alu_data1), .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_out2(alu_out2),
    .alu_out3(alu_out3), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flag_ovf(flag_ovf), .flag_zero(flag_zero),
    .retired_count(retired_count), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Bit 8 is carry (add) or borrow (sub); the ALU drives the result only on the selected port
  function automatic logic [8:0] alu_fn(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b);
    case (i[13:10])
      4'b0000: return {1'b0, a};
      4'b0001: return {1'b0, b};
      4'b0010: return {1'b0, a} + {1'b0, b};
      4'b0011: return {1'b0, a} - {1'b0, b};
      4'b0100: return {1'b0, a & b};
      4'b0101: return {1'b0, a | b};
      4'b0110: return {1'b0, a ^ b};
      4'b0111: return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_instruction, alu_data0, alu_data1);
  assign alu_out0 = alu_instruction[15:14] == 2'd0 ? alu_r[7:0] : 8'h00;
  assign alu_out1 = alu_instruction[15:14] == 2'd1 ? alu_r[7:0] : 8'h00;
  assign alu_out2 = alu_instruction[15:14] == 2'd2 ? alu_r[7:0] : 8'h00;
  assign alu_out3 = alu_instruction[15:14] == 2'd3 ? alu_r[7:0] : 8'h00;
  assign alu_zero = alu_r[7:0] == 8'h00;
  assign alu_overflow = alu_r[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] i);
    logic [8:0] r;
    if (i[13:12] == 2'b10) return;
    r = alu_fn(i, m_regs[i[9:8]], i[5] ? {3'b000, i[4:0]} : m_regs[i[7:6]]);
    m_regs[i[15:14]] = r[7:0];
    exp_q.push_back({i[15:14], r[7:0]});
  endtask

  task automatic push(input logic [15:0] i, input bit track);
    in_valid = 1'b1;
    in_instr = i;
    if (track) model(i);
    @(negedge clk); #1;
    in_valid = 1'b0;
    push_edge = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_wb(input int n);
    for (int k = 0; k < 20 && wb_cnt < n; k++) begin @(negedge clk); #1; end
    chk("wb_count", wb_cnt, n);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && wb_valid) begin
      prev_wb = last_wb;
      last_wb = cyc;
      wb_cnt++;
      if (exp_q.size() == 0) chk("wb_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("wb_addr", wb_addr, e[9:8]);
        chk("wb_data", wb_data, e[7:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; resume = 1'b0; flush = 1'b0; dbg_addr = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_halted", halted, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_instr", alu_instruction, 0);
    rd(2'd1, 8'h00, "rst_r1");
    @(negedge clk); #1;
    rst = 1'b0;
    push(16'h4825, 1'b1);
    pe = push_edge;
    wait_wb(1);
    chk("t1_latency", last_wb - pe, 2);
    chk("t1_zero", flag_zero, 0);
    chk("t1_retired", retired_count, 1);
    rd(2'd1, 8'h05, "t1_r1");
    push(16'h4825, 1'b1);
    push(16'h8923, 1'b1);
    wait_wb(3);
    chk("t2_no_bubble", last_wb - prev_wb, 1);
    chk("t2_retired", retired_count, 3);
    rd(2'd2, 8'h08, "t2_r2_fwd");
    push(16'hCC21, 1'b1);
    push(16'h0BC0, 1'b1);
    wait_wb(5);
    rd(2'd3, 8'hFF, "t3_r3");
    rd(2'd0, 8'hFE, "t3_r0");
    chk("t3_ovf", flag_ovf, 1);
    push(16'h4821, 1'b1);
    wait_wb(6);
    chk("t3_ovf_sticky", flag_ovf, 1);
    chk("t3_zero", flag_zero, 0);
    rd(2'd1, 8'hFF, "t3_r1");
    rc = int'(retired_count);
    base = wb_cnt;
    push(16'h2C00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) chk("halt_in_ready_full", in_ready, 0);
      push(hv[k], k < 4);
    end
    idle(4);
    chk("halt_halted", halted, 1);
    chk("halt_retired", retired_count, rc + 1);
    chk("halt_no_wb", wb_cnt, base);
    resume = 1'b1;
    idle(1);
    resume = 1'b0;
    wait_wb(base + 4);
    idle(3);
    chk("resume_retired", retired_count, rc + 5);
    chk("resume_halted", halted, 0);
    chk("resume_zero", flag_zero, 1);
    chk("resume_in_ready", in_ready, 1);
    chk("sb_drain", exp_q.size(), 0);
    rd(2'd2, 8'hFF, "resume_r2");
    rd(2'd3, 8'h01, "resume_r3");
    rd(2'd0, 8'h00, "resume_r0");
    resume = 1'b1;
    idle(1);
    resume = 1'b0;
    idle(1);
    chk("resume_ignored", halted, 0);
    rc = int'(retired_count);
    base = wb_cnt;
    push(16'h2000, 1'b1);
    idle(4);
    chk("nop_retired", retired_count, rc + 1);
    chk("nop_no_wb", wb_cnt, base);
    chk("nop_zero_kept", flag_zero, 1);
    chk("nop_ovf_kept", flag_ovf, 1);
    rc = int'(retired_count);
    push(16'h4825, 1'b0);
    idle(1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h4825;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    idle(4);
    chk("flush_no_wb", wb_cnt, base);
    chk("flush_retired", retired_count, rc + 1);
    chk("flush_halted", halted, 0);
    chk("flush_in_ready", in_ready, 1);
    rd(2'd1, 8'h00, "flush_r1");
    in_valid = 1'b1;
    in_instr = 16'h4825;
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("arst_instr", alu_instruction, 0);
    chk("arst_data1", alu_data1, 0);
    chk("arst_retired", retired_count, 0);
    chk("arst_ovf", flag_ovf, 0);
    chk("arst_zero", flag_zero, 0);
    chk("arst_wb_valid", wb_valid, 0);
    for (int k = 0; k < 4; k++) rd(2'(k), 8'h00, "arst_reg");
    exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk("arst_no_wb", wb_cnt, base);
    chk("arst_retired_after", retired_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
